// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains 16-bit samples from a FIFO read port and sends each one
// over an 8N1 UART line as two bytes, high byte first.
//
// Ports
//   clk           system clock, rising-edge
//   rst           synchronous reset, active-high, priority over all inputs
//   enable        allows a new sample transfer to start from IDLE
//   dato_in[15:0] FIFO read data, valid the cycle after rd_en
//   empty         FIFO empty flag, only looked at in IDLE
//   rd_en         one-cycle FIFO read strobe per sample
//   tx            UART serial line, idle high, registered
//   busy          high whenever the FSM is not in IDLE
//   samples_sent  number of fully transmitted samples, wraps silently
//
// State  | meaning
// IDLE   | line idle, waiting for enable=1 and empty=0
// RD     | rd_en asserted for one cycle
// WAIT   | FIFO data valid, latch sample and clear counters
// START  | start bit (0) for CLKS_PER_BIT cycles
// DATA   | 8 data bits LSB first, CLKS_PER_BIT cycles each
// STOP   | stop bit (1); loops to START for the low byte, else back to IDLE

module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] dato_in,
    input  logic        empty,
    output logic        rd_en,
    output logic        tx,
    output logic        busy,
    output logic [15:0] samples_sent
);

    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_TC  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE = BW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     sample_q, sample_d;
    logic            byte_idx_q, byte_idx_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic            tail_q, tail_d;
    logic            tx_q, tx_d;
    logic [15:0]     cnt_q, cnt_d;

    logic            baud_tc;
    logic [7:0]      cur_byte;

    assign baud_tc  = (baud_q == BAUD_TC);
    assign cur_byte = byte_idx_q ? sample_q[7:0] : sample_q[15:8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sample_q   <= '0;
            byte_idx_q <= 1'b0;
            bit_cnt_q  <= '0;
            baud_q     <= '0;
            tail_q     <= 1'b0;
            tx_q       <= 1'b1;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            sample_q   <= sample_d;
            byte_idx_q <= byte_idx_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_q     <= baud_d;
            tail_q     <= tail_d;
            tx_q       <= tx_d;
            cnt_q      <= cnt_d;
        end
    end

    // tx is registered from the current state, so the line trails the state
    // register by one cycle. The final stop bit therefore holds STOP one extra
    // cycle (tail_q) so busy stays high until the last stop bit has left the pin.
    always_comb begin
        state_d    = state_q;
        sample_d   = sample_q;
        byte_idx_d = byte_idx_q;
        bit_cnt_d  = bit_cnt_q;
        baud_d     = baud_q;
        tail_d     = tail_q;
        cnt_d      = cnt_q;
        tx_d       = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (enable && !empty) begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                sample_d   = dato_in;
                byte_idx_d = 1'b0;
                bit_cnt_d  = '0;
                baud_d     = '0;
                tail_d     = 1'b0;
                state_d    = S_START;
            end
            S_START: begin
                tx_d = 1'b0;
                if (baud_tc) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_DATA: begin
                tx_d = cur_byte[bit_cnt_q];
                if (baud_tc) begin
                    baud_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        state_d   = S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (tail_q) begin
                    tail_d  = 1'b0;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = S_IDLE;
                end else if (baud_tc) begin
                    baud_d = '0;
                    if (!byte_idx_q) begin
                        byte_idx_d = 1'b1;
                        state_d    = S_START;
                    end else begin
                        tail_d = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rd_en        = (state_q == S_RD);
    assign busy         = (state_q != S_IDLE);
    assign tx           = tx_q;
    assign samples_sent = cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

    localparam int C     = 4;
    localparam int FRAME = 20 * C;      // two 10-bit characters
    localparam int BUSY  = 3 + FRAME;   // busy cycles per sample

    typedef int          iq_t[$];
    typedef logic [15:0] vq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] dato_in = 16'h0;
    logic        empty = 1'b1;
    logic        rd_en, tx, busy;
    logic [15:0] samples_sent;

    int compared = 0;
    int mismatched = 0;

    logic        tx_log[$], busy_log[$], rd_log[$];
    logic [15:0] fifo_q[$];
    logic [15:0] exp_cnt;

    fifo_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst(rst), .enable(enable), .dato_in(dato_in), .empty(empty),
        .rd_en(rd_en), .tx(tx), .busy(busy), .samples_sent(samples_sent)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (line-level view of a sample) --------
    // k-th cycle of the 20-bit-period frame for sample v
    function automatic logic frame_bit(logic [15:0] v, int k);
        int half = k / (10 * C);
        int j = (k % (10 * C)) / C;
        logic [7:0] b = (half == 0) ? v[15:8] : v[7:0];
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j-1];
    endfunction

    // expected line level at log index i, given read strobes r and sample values v
    function automatic logic exp_tx(int i, iq_t r, vq_t v);
        for (int n = 0; n < r.size() && n < v.size(); n++)
            if (i >= r[n] + 3 && i < r[n] + 3 + FRAME) return frame_bit(v[n], i - r[n] - 3);
        return 1'b1;
    endfunction

    function automatic logic exp_busy(int i, iq_t r);
        foreach (r[n]) if (i >= r[n] && i < r[n] + BUSY) return 1'b1;
        return 1'b0;
    endfunction

    // UART receiver: sample mid-bit of character ch of a frame starting at s
    function automatic logic [7:0] decode(int s, int ch);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = tx_log[s + ch*10*C + (k+1)*C + C/2];
        return b;
    endfunction

    function automatic iq_t rd_positions();
        iq_t p;
        foreach (rd_log[i]) if (rd_log[i] === 1'b1) p.push_back(i);
        return p;
    endfunction

    // ---------------- stimulus plumbing -------------------------------------
    // Outputs are sampled at the falling edge; the FIFO pops when it sees rd_en,
    // so dato_in is valid through the following cycle (one-cycle read latency).
    task automatic tick();
        @(negedge clk);
        tx_log.push_back(tx);
        busy_log.push_back(busy);
        rd_log.push_back(rd_en);
        if (rd_en === 1'b1 && fifo_q.size() > 0) dato_in = fifo_q.pop_front();
        empty = (fifo_q.size() == 0);
    endtask

    task automatic capture(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_logs();
        tx_log.delete(); busy_log.delete(); rd_log.delete();
    endtask

    task automatic push(input logic [15:0] v);
        fifo_q.push_back(v);
        empty = 1'b0;
    endtask

    // ---------------- tests --------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; enable = 1'b1;
        push(16'h1234);
        capture(3);
        compared++; if (tx !== 1'b1) begin mismatched++; $display("FAIL reset_tx got %b want 1", tx); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", busy); end
        compared++; if (rd_en !== 1'b0) begin mismatched++; $display("FAIL reset_rd_en got %b want 0", rd_en); end
        compared++; if (samples_sent !== 16'h0) begin mismatched++; $display("FAIL reset_count got %h want 0000", samples_sent); end
        enable = 1'b0;
        fifo_q.delete(); empty = 1'b1;
        rst = 1'b0;
        exp_cnt = 16'h0;
        capture(2);
    endtask

    task automatic test_single();
        iq_t r; vq_t v; int bad = 0, nb = 0; logic [7:0] hi, lo;
        v.push_back(16'hA55A);
        clear_logs(); push(16'hA55A); enable = 1'b1;
        capture(100);
        enable = 1'b0; exp_cnt++;
        r = rd_positions();
        compared++; if (r.size() != 1) begin mismatched++; $display("FAIL single_rd_count got %0d want 1", r.size()); end
        else begin
            compared++; if (r[0] != 0) begin mismatched++; $display("FAIL single_rd_pos got %0d want 0", r[0]); end
            foreach (tx_log[i]) if (tx_log[i] !== exp_tx(i, r, v)) bad++;
            compared++; if (bad != 0) begin mismatched++; $display("FAIL single_tx_wave got %0d bad cycles want 0", bad); end
            hi = decode(r[0] + 3, 0); lo = decode(r[0] + 3, 1);
            compared++; if (hi !== 8'hA5) begin mismatched++; $display("FAIL single_byte0 got %h want a5", hi); end
            compared++; if (lo !== 8'h5A) begin mismatched++; $display("FAIL single_byte1 got %h want 5a", lo); end
        end
        foreach (busy_log[i]) if (busy_log[i] === 1'b1) nb++;
        compared++; if (nb != BUSY) begin mismatched++; $display("FAIL single_busy_cycles got %0d want %0d", nb, BUSY); end
        compared++; if (samples_sent !== exp_cnt) begin mismatched++; $display("FAIL single_count got %h want %h", samples_sent, exp_cnt); end
    endtask

    task automatic test_empty();
        int nrd = 0, ntx = 0, nbusy = 0;
        clear_logs(); enable = 1'b1;
        capture(100);
        enable = 1'b0;
        foreach (rd_log[i]) begin
            if (rd_log[i] !== 1'b0) nrd++;
            if (tx_log[i] !== 1'b1) ntx++;
            if (busy_log[i] !== 1'b0) nbusy++;
        end
        compared++; if (nrd != 0) begin mismatched++; $display("FAIL empty_rd_en got %0d pulses want 0", nrd); end
        compared++; if (ntx != 0) begin mismatched++; $display("FAIL empty_tx got %0d low cycles want 0", ntx); end
        compared++; if (nbusy != 0) begin mismatched++; $display("FAIL empty_busy got %0d busy cycles want 0", nbusy); end
    endtask

    task automatic test_back_to_back();
        iq_t r; vq_t v; int bad = 0; logic [7:0] got[4]; logic [7:0] want[4];
        want = '{8'h00, 8'h01, 8'hFF, 8'hFF};
        v.push_back(16'h0001); v.push_back(16'hFFFF);
        clear_logs(); push(16'h0001); push(16'hFFFF); enable = 1'b1;
        capture(2 * (BUSY + 1) + 10);
        enable = 1'b0; exp_cnt += 16'd2;
        r = rd_positions();
        compared++; if (r.size() != 2) begin mismatched++; $display("FAIL b2b_rd_count got %0d want 2", r.size()); end
        else begin
            compared++; if (r[1] - r[0] != BUSY + 1) begin mismatched++; $display("FAIL b2b_rd_spacing got %0d want %0d", r[1] - r[0], BUSY + 1); end
            foreach (tx_log[i]) if (tx_log[i] !== exp_tx(i, r, v) || busy_log[i] !== exp_busy(i, r)) bad++;
            compared++; if (bad != 0) begin mismatched++; $display("FAIL b2b_wave got %0d bad cycles want 0", bad); end
            got[0] = decode(r[0] + 3, 0); got[1] = decode(r[0] + 3, 1);
            got[2] = decode(r[1] + 3, 0); got[3] = decode(r[1] + 3, 1);
            for (int k = 0; k < 4; k++) begin
                compared++; if (got[k] !== want[k]) begin mismatched++; $display("FAIL b2b_byte%0d got %h want %h", k, got[k], want[k]); end
            end
        end
        compared++; if (samples_sent !== exp_cnt) begin mismatched++; $display("FAIL b2b_count got %h want %h", samples_sent, exp_cnt); end
    endtask

    task automatic test_enable_drop();
        iq_t r; vq_t v; int bad = 0;
        logic [15:0] a = 16'($urandom), b = 16'($urandom);
        v.push_back(a);
        clear_logs(); push(a); push(b); enable = 1'b1;
        capture(3 + C + 2);                 // now inside DATA of the first byte
        enable = 1'b0;
        capture(2 * BUSY);
        exp_cnt++;
        r = rd_positions();
        compared++; if (r.size() != 1) begin mismatched++; $display("FAIL drop_rd_count got %0d want 1", r.size()); end
        else begin
            foreach (tx_log[i]) if (tx_log[i] !== exp_tx(i, r, v) || busy_log[i] !== exp_busy(i, r)) bad++;
            compared++; if (bad != 0) begin mismatched++; $display("FAIL drop_wave got %0d bad cycles want 0", bad); end
        end
        compared++; if (fifo_q.size() != 1) begin mismatched++; $display("FAIL drop_fifo_level got %0d want 1", fifo_q.size()); end
        compared++; if (samples_sent !== exp_cnt) begin mismatched++; $display("FAIL drop_count got %h want %h", samples_sent, exp_cnt); end
        // re-enable and drain the sample that was left behind
        v.delete(); v.push_back(b); bad = 0;
        clear_logs(); enable = 1'b1;
        capture(BUSY + 5);
        enable = 1'b0; exp_cnt++;
        r = rd_positions();
        compared++; if (r.size() != 1) begin mismatched++; $display("FAIL drop_resume_rd got %0d want 1", r.size()); end
        else begin
            foreach (tx_log[i]) if (tx_log[i] !== exp_tx(i, r, v)) bad++;
            compared++; if (bad != 0) begin mismatched++; $display("FAIL drop_resume_wave got %0d bad cycles want 0", bad); end
        end
    endtask

    task automatic test_reset_mid();
        iq_t r; vq_t v; int bad = 0;
        logic [15:0] a = 16'($urandom), b = 16'($urandom);
        clear_logs(); push(a); push(b); enable = 1'b1;
        capture(3 + 10*C + C + 3);          // inside DATA of the second byte
        rst = 1'b1;
        capture(1);
        exp_cnt = 16'h0;
        compared++; if (tx !== 1'b1) begin mismatched++; $display("FAIL rstmid_tx got %b want 1", tx); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rstmid_busy got %b want 0", busy); end
        compared++; if (samples_sent !== 16'h0) begin mismatched++; $display("FAIL rstmid_count got %h want 0000", samples_sent); end
        rst = 1'b0;
        v.push_back(b);
        clear_logs();
        capture(BUSY + 5);
        enable = 1'b0; exp_cnt++;
        r = rd_positions();
        compared++; if (r.size() != 1) begin mismatched++; $display("FAIL rstmid_rd_count got %0d want 1", r.size()); end
        else begin
            foreach (tx_log[i]) if (tx_log[i] !== exp_tx(i, r, v)) bad++;
            compared++; if (bad != 0) begin mismatched++; $display("FAIL rstmid_fresh_wave got %0d bad cycles want 0", bad); end
        end
        compared++; if (samples_sent !== exp_cnt) begin mismatched++; $display("FAIL rstmid_after_count got %h want %h", samples_sent, exp_cnt); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            iq_t r; vq_t v; int bad = 0;
            int n = $urandom_range(1, 3);
            int gap = $urandom_range(0, 6);
            clear_logs();
            for (int k = 0; k < n; k++) begin
                logic [15:0] s = 16'($urandom);
                v.push_back(s); push(s);
            end
            capture(gap);                   // enable low: nothing may start
            enable = 1'b1;
            capture(n * (BUSY + 1) + 8);
            enable = 1'b0; exp_cnt += 16'(n);
            r = rd_positions();
            compared++; if (r.size() != n) begin mismatched++; $display("FAIL rand%0d_rd_count got %0d want %0d", it, r.size(), n); end
            else begin
                compared++; if (r[0] != gap) begin mismatched++; $display("FAIL rand%0d_first_rd got %0d want %0d", it, r[0], gap); end
                for (int k = 1; k < n; k++) if (r[k] - r[k-1] != BUSY + 1) bad++;
                foreach (tx_log[i]) if (tx_log[i] !== exp_tx(i, r, v) || busy_log[i] !== exp_busy(i, r)) bad++;
                compared++; if (bad != 0) begin mismatched++; $display("FAIL rand%0d_wave got %0d bad cycles want 0", it, bad); end
            end
            compared++; if (samples_sent !== exp_cnt) begin mismatched++; $display("FAIL rand%0d_count got %h want %h", it, samples_sent, exp_cnt); end
        end
    endtask

    task automatic test_wrap();
        force dut.cnt_q = 16'hFFFF;
        capture(2);
        release dut.cnt_q;
        capture(1);
        exp_cnt = 16'hFFFF;
        compared++; if (samples_sent !== exp_cnt) begin mismatched++; $display("FAIL wrap_preset got %h want %h", samples_sent, exp_cnt); end
        clear_logs(); push(16'($urandom)); enable = 1'b1;
        capture(BUSY + 5);
        enable = 1'b0; exp_cnt++;
        compared++; if (samples_sent !== 16'h0000) begin mismatched++; $display("FAIL wrap_rollover got %h want 0000", samples_sent); end
        compared++; if (samples_sent !== exp_cnt) begin mismatched++; $display("FAIL wrap_model got %h want %h", samples_sent, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_empty();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per UART bit (115200 baud at 100 MHz); legal range 2..65535.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 enable  input  1  high permits starting a new sample transfer.
REQ-005 dato_in  input  16  filtered sample from the FIFO read port (dato_out of memoria).
REQ-006 empty  input  1  FIFO empty flag.
REQ-007 rd_en  output  1  FIFO read strobe, one-cycle pulse per sample.
REQ-008 tx  output  1  UART serial line, 8N1, idle high.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 samples_sent  output  16  count of fully transmitted samples.

Function
REQ-011 FSM states: IDLE, RD, WAIT, START, DATA, STOP; registered state, one state per clock edge except where bit timing holds it.
REQ-012 IDLE -> RD when enable=1 and empty=0 on the same edge; otherwise remain IDLE.
REQ-013 rd_en = 1 only while state = RD; exactly one cycle per sample; never asserted when empty was 1 at the IDLE decision.
REQ-014 RD -> WAIT unconditionally; FIFO read latency is one cycle, so dato_in is valid during WAIT.
REQ-015 WAIT: latch dato_in into 16-bit sample register, clear byte index to 0, bit counter to 0, baud counter to 0; -> START.
REQ-016 Byte order: byte index 0 sends sample[15:8], byte index 1 sends sample[7:0].
REQ-017 START: tx=0 for exactly CLKS_PER_BIT cycles, then -> DATA.
REQ-018 DATA: 8 bits LSB first, each held exactly CLKS_PER_BIT cycles; after bit 7 -> STOP.
REQ-019 STOP: tx=1 for exactly CLKS_PER_BIT cycles; then if byte index = 0, set byte index = 1 and -> START (no inter-byte gap); else increment samples_sent and -> IDLE.
REQ-020 tx = 1 in IDLE, RD, WAIT and STOP; tx registered, glitch-free.
REQ-021 First start-bit cycle occurs 3 cycles after the IDLE edge that saw enable=1, empty=0; one sample occupies 3 + 20*CLKS_PER_BIT cycles from that edge back to IDLE.
REQ-022 enable deasserted mid-sample: current sample completes both bytes; no further rd_en until enable=1.
REQ-023 empty is ignored outside IDLE; back-to-back samples: IDLE lasts one cycle between samples when enable=1 and empty=0.
REQ-024 samples_sent wraps 0xFFFF -> 0x0000 without flag.
REQ-025 Baud counter width = ceil(log2(CLKS_PER_BIT)) bits; no off-by-one: bit period exactly CLKS_PER_BIT cycles.

Reset
REQ-026 rst=1 at any edge forces, at that edge: state=IDLE, tx=1, rd_en=0, busy=0, samples_sent=0, sample register=0, all counters=0.
REQ-027 rst mid-frame aborts the frame immediately; the partially sent sample is lost and not re-read.
REQ-028 rst has priority over every other input.

Verification (CLKS_PER_BIT=4)
REQ-029 FIFO holds 0xA55A, enable=1 -> one rd_en pulse; tx sequence 0,01010101b... i.e. start,A5 LSB-first (1,0,1,0,0,1,0,1),stop,start,5A LSB-first (0,1,0,1,1,0,1,0),stop, each bit 4 cycles; samples_sent=1; busy high for 83 cycles.
REQ-030 empty=1, enable=1 for 100 cycles -> rd_en never asserted, tx=1, busy=0.
REQ-031 FIFO holds 0x0001,0xFFFF back-to-back -> two rd_en pulses separated by 84 cycles; decoded bytes 00,01,FF,FF; samples_sent=2.
REQ-032 enable dropped during DATA of first byte -> both bytes still sent, no second rd_en, returns to IDLE.
REQ-033 rst pulsed during DATA of second byte -> next edge tx=1, busy=0, samples_sent=0; following sample read fresh from FIFO.
REQ-034 samples_sent preset by 65535 transfers (or forced in sim) -> next completed sample gives 0x0000.
